// File: rtl/load_store_sequencer.sv
// ---------------------------------------------------------------------------
// load_store_sequencer
//
// Sequences a single MIPS-style load or store onto a word-wide memory port
// with a waitrequest handshake. A request is accepted in IDLE, the memory
// access is held in ACCESS until the memory stops stalling, and the result
// is presented for exactly one cycle in DONE. Memory bytes are big-endian
// (byte offset 0 lives in bits [31:24]).
//
// Op codes: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW.
// All other codes complete immediately as no-ops with load_data = 0.
//
// Optional feature (compile-time macro LSU_ALIGN_CHECK_EN):
//   adds output err. Misaligned LH/LHU/SH/LW/SW skip the memory access and
//   complete at once with err = 1 and load_data = 0. Without the macro,
//   misaligned accesses silently use the truncated (aligned-down) address.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   start             request strobe, sampled only in IDLE
//   op[3:0]           operation code (see above)
//   addr[31:0]        byte address
//   store_data[31:0]  value for SB/SH/SW
//   rt_data[31:0]     old rt value, merged into LWL/LWR results
//   busy              high in ACCESS and DONE
//   done              one-cycle completion pulse
//   load_data[31:0]   load result, valid while done = 1
//   err               (LSU_ALIGN_CHECK_EN only) misalignment flag with done
//   data_address      word-aligned memory address
//   data_read         memory read strobe
//   data_write        memory write strobe
//   data_byteenable   byte lane enables (bit 3 = bits [31:24])
//   data_writedata    replicated store data
//   data_readdata     memory read data
//   data_waitrequest  memory stall; access outputs held while high
// ---------------------------------------------------------------------------
module load_store_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
`ifdef LSU_ALIGN_CHECK_EN
  output logic        err,
`endif
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_byteenable,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  function automatic logic is_valid_op(input logic [3:0] o);
    return (o <= OP_LWR) || (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [3:0] o, input logic [1:0] a);
    case (o)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_store_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_load_data;

  logic        w_accept;
  logic        w_in_valid;
  logic        w_is_load;
  logic [4:0]  w_lane_shift;
  logic [4:0]  w_left_shift;
  logic [31:0] w_rd_shifted;
  logic [15:0] w_half;
  logic [31:0] w_load_result;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_wdata;

`ifdef LSU_ALIGN_CHECK_EN
  logic        r_err;
  logic        w_in_misaligned;
  assign w_in_misaligned = is_misaligned(op, addr[1:0]);
`endif

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_in_valid = is_valid_op(op);
  // Only valid ops ever reach ACCESS, so bit 3 cleanly splits loads/stores.
  assign w_is_load  = ~r_op[3];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case/if tree leaves it unassigned (which infers a latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!w_in_valid)          w_next_state = ST_DONE;
`ifdef LSU_ALIGN_CHECK_EN
          else if (w_in_misaligned) w_next_state = ST_DONE;
`endif
          else                      w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: if (!data_waitrequest) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= 4'h0;
      r_addr       <= 32'h0;
      r_store_data <= 32'h0;
      r_rt_data    <= 32'h0;
      r_load_data  <= 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
      r_err        <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_op         <= op;
        r_addr       <= addr;
        r_store_data <= store_data;
        r_rt_data    <= rt_data;
        // Cleared here so no-op and rejected requests report zero in DONE.
        r_load_data  <= 32'h0;
      end
      if ((r_state == ST_ACCESS) && !data_waitrequest)
        r_load_data <= w_load_result;
`ifdef LSU_ALIGN_CHECK_EN
      // Set only on the IDLE->DONE rejection edge, so it drops after DONE.
      r_err <= w_accept && w_in_valid && w_in_misaligned;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction (big-endian: offset k sits at bits [31-8k -: 8])
  // ---------------------------------------------------------------------------
  always_comb begin
    // Shift by 8*(3-k) brings byte k down to [7:0]; ~k == 3-k for 2 bits.
    w_lane_shift  = {~r_addr[1:0], 3'b000};
    w_left_shift  = {r_addr[1:0], 3'b000};
    w_rd_shifted  = data_readdata >> w_lane_shift;
    w_half        = r_addr[1] ? data_readdata[15:0] : data_readdata[31:16];
    w_load_result = 32'h0;
    case (r_op)
      OP_LB:  w_load_result = {{24{w_rd_shifted[7]}}, w_rd_shifted[7:0]};
      OP_LBU: w_load_result = {24'h0, w_rd_shifted[7:0]};
      OP_LH:  w_load_result = {{16{w_half[15]}}, w_half};
      OP_LHU: w_load_result = {16'h0, w_half};
      OP_LW:  w_load_result = data_readdata;
      // Memory bytes k..3 go to the top; rt keeps its low k bytes.
      OP_LWL: w_load_result = (data_readdata << w_left_shift) |
                              (r_rt_data & ~(32'hFFFF_FFFF << w_left_shift));
      // Memory bytes 0..k go to the bottom; rt keeps its upper 3-k bytes.
      OP_LWR: w_load_result = w_rd_shifted |
                              (r_rt_data & ~(32'hFFFF_FFFF >> w_lane_shift));
      default: w_load_result = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store lane enables and replicated data
  // ---------------------------------------------------------------------------
  always_comb begin
    w_store_be    = 4'h0;
    w_store_wdata = 32'h0;
    case (r_op)
      OP_SB: begin
        w_store_be    = 4'b1000 >> r_addr[1:0];
        w_store_wdata = {4{r_store_data[7:0]}};
      end
      OP_SH: begin
        w_store_be    = r_addr[1] ? 4'b0011 : 4'b1100;
        w_store_wdata = {2{r_store_data[15:0]}};
      end
      OP_SW: begin
        w_store_be    = 4'b1111;
        w_store_wdata = r_store_data;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: memory side is driven from latched state only, so it stays
  // stable for as long as the memory stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_address    = 32'h0;
    data_read       = 1'b0;
    data_write      = 1'b0;
    data_byteenable = 4'h0;
    data_writedata  = 32'h0;
    if (r_state == ST_ACCESS) begin
      data_address = {r_addr[31:2], 2'b00};
      if (w_is_load) begin
        data_read       = 1'b1;
        data_byteenable = 4'b1111;
      end else begin
        data_write      = 1'b1;
        data_byteenable = w_store_be;
        data_writedata  = w_store_wdata;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign load_data = r_load_data;
`ifdef LSU_ALIGN_CHECK_EN
  assign err       = r_err;
`endif

endmodule

// File: tb/tb_load_store_sequencer.sv
// ---------------------------------------------------------------------------
// tb_load_store_sequencer
//
// Directed bench for load_store_sequencer. Inputs change 1 ns after a rising
// edge; outputs are sampled on the falling edge. Each scenario task drives
// its own stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_load_store_sequencer;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
`ifdef LSU_ALIGN_CHECK_EN
  logic        err;
`endif
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .addr             (addr),
    .store_data       (store_data),
    .rt_data          (rt_data),
    .busy             (busy),
    .done             (done),
    .load_data        (load_data),
`ifdef LSU_ALIGN_CHECK_EN
    .err              (err),
`endif
    .data_address     (data_address),
    .data_read        (data_read),
    .data_write       (data_write),
    .data_byteenable  (data_byteenable),
    .data_writedata   (data_writedata),
    .data_readdata    (data_readdata),
    .data_waitrequest (data_waitrequest)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [3:0]  be;
    logic [31:0] wd;
  } st_vec_t;

  ld_vec_t ld_vecs [18] = '{
    '{OP_LB,  32'h103, 32'h11223344, 32'h000000F0, 32'hFFFFFFF0},
    '{OP_LBU, 32'h103, 32'h11223344, 32'h000000F0, 32'h000000F0},
    '{OP_LB,  32'h100, 32'h11223344, 32'h7F000000, 32'h0000007F},
    '{OP_LB,  32'h101, 32'h11223344, 32'h00800000, 32'hFFFFFF80},
    '{OP_LBU, 32'h102, 32'h11223344, 32'h0000C300, 32'h000000C3},
    '{OP_LH,  32'h102, 32'h11223344, 32'h1234ABCD, 32'hFFFFABCD},
    '{OP_LHU, 32'h102, 32'h11223344, 32'h1234ABCD, 32'h0000ABCD},
    '{OP_LH,  32'h100, 32'h11223344, 32'h8234ABCD, 32'hFFFF8234},
    '{OP_LHU, 32'h100, 32'h11223344, 32'h8234ABCD, 32'h00008234},
    '{OP_LW,  32'h104, 32'h11223344, 32'hDEADBEEF, 32'hDEADBEEF},
    '{OP_LWL, 32'h101, 32'h11223344, 32'hAABBCCDD, 32'hBBCCDD44},
    '{OP_LWR, 32'h101, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB},
    '{OP_LWL, 32'h100, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD},
    '{OP_LWL, 32'h102, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344},
    '{OP_LWL, 32'h103, 32'h11223344, 32'hAABBCCDD, 32'hDD223344},
    '{OP_LWR, 32'h100, 32'h11223344, 32'hAABBCCDD, 32'h112233AA},
    '{OP_LWR, 32'h102, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC},
    '{OP_LWR, 32'h103, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD}
  };

  st_vec_t st_vecs [6] = '{
    '{OP_SB, 32'h200, 32'h12345678, 4'b1000, 32'h78787878},
    '{OP_SB, 32'h201, 32'h12345678, 4'b0100, 32'h78787878},
    '{OP_SB, 32'h203, 32'h000000A5, 4'b0001, 32'hA5A5A5A5},
    '{OP_SH, 32'h200, 32'h12345678, 4'b1100, 32'h56785678},
    '{OP_SH, 32'h202, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF},
    '{OP_SW, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D}
  };

  // One-cycle start pulse; returns 1 ns after the edge that sampled it.
  task automatic start_op(input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rt);
    @(posedge clk); #1;
    op = o; addr = a; store_data = sd; rt_data = rt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'h0; addr = 32'h0;
    store_data = 32'h0; rt_data = 32'h0;
    data_readdata = 32'h0; data_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, data_read, data_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got busy/done/rd/wr %b expected 0000",
                         {busy, done, data_read, data_write});
    end
    checks++;
    if (load_data !== 32'h0) begin
      errors++; $display("FAIL reset_load_data: got %h expected 00000000", load_data);
    end
    checks++;
    if (data_address !== 32'h0) begin
      errors++; $display("FAIL reset_address: got %h expected 00000000", data_address);
    end
    checks++;
    if (data_writedata !== 32'h0) begin
      errors++; $display("FAIL reset_writedata: got %h expected 00000000", data_writedata);
    end
    checks++;
    if (data_byteenable !== 4'h0) begin
      errors++; $display("FAIL reset_byteenable: got %b expected 0000", data_byteenable);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    data_waitrequest = 1'b0; data_readdata = 32'h11223344;
    start_op(OP_LW, 32'h100, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({busy, done, data_read, data_write} !== 4'b1010) begin
      errors++; $display("FAIL lw_access_ctrl: got busy/done/rd/wr %b expected 1010",
                         {busy, done, data_read, data_write});
    end
    checks++;
    if (data_address !== 32'h100) begin
      errors++; $display("FAIL lw_address: got %h expected 00000100", data_address);
    end
    checks++;
    if (data_byteenable !== 4'b1111) begin
      errors++; $display("FAIL lw_byteenable: got %b expected 1111", data_byteenable);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, data_read, data_write} !== 4'b1100) begin
      errors++; $display("FAIL lw_done_ctrl: got busy/done/rd/wr %b expected 1100",
                         {busy, done, data_read, data_write});
    end
    checks++;
    if (load_data !== 32'h11223344) begin
      errors++; $display("FAIL lw_load_data: got %h expected 11223344", load_data);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL lw_idle: got busy/done %b expected 00", {busy, done});
    end
  endtask

  task automatic test_loads();
    data_waitrequest = 1'b0;
    foreach (ld_vecs[i]) begin
      data_readdata = ld_vecs[i].rd;
      start_op(ld_vecs[i].op, ld_vecs[i].addr, 32'h0, ld_vecs[i].rt);
      @(negedge clk);
      checks++;
      if (!(data_read === 1'b1 && data_write === 1'b0 && data_byteenable === 4'b1111 &&
            data_address === {ld_vecs[i].addr[31:2], 2'b00})) begin
        errors++;
        $display("FAIL load_access[%0d]: got rd %b wr %b be %b addr %h expected rd 1 wr 0 be 1111 addr %h",
                 i, data_read, data_write, data_byteenable, data_address,
                 {ld_vecs[i].addr[31:2], 2'b00});
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || load_data !== ld_vecs[i].exp) begin
        errors++;
        $display("FAIL load_data[%0d]: got done %b data %h expected done 1 data %h",
                 i, done, load_data, ld_vecs[i].exp);
      end
    end
  endtask

  task automatic test_stores();
    data_waitrequest = 1'b0;
    foreach (st_vecs[i]) begin
      start_op(st_vecs[i].op, st_vecs[i].addr, st_vecs[i].sd, 32'h0);
      @(negedge clk);
      checks++;
      if (!(data_write === 1'b1 && data_read === 1'b0 && data_byteenable === st_vecs[i].be &&
            data_writedata === st_vecs[i].wd &&
            data_address === {st_vecs[i].addr[31:2], 2'b00})) begin
        errors++;
        $display("FAIL store_access[%0d]: got wr %b rd %b be %b wd %h addr %h expected be %b wd %h",
                 i, data_write, data_read, data_byteenable, data_writedata, data_address,
                 st_vecs[i].be, st_vecs[i].wd);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || data_write !== 1'b0 || data_byteenable !== 4'h0) begin
        errors++;
        $display("FAIL store_done[%0d]: got done %b wr %b be %b expected done 1 wr 0 be 0000",
                 i, done, data_write, data_byteenable);
      end
    end
  endtask

  task automatic test_wait_state();
    data_waitrequest = 1'b1;
    start_op(OP_SB, 32'h202, 32'h0000005A, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (!(data_write === 1'b1 && data_byteenable === 4'b0010 &&
            data_writedata === 32'h5A5A5A5A && data_address === 32'h200 && done === 1'b0)) begin
        errors++;
        $display("FAIL wait_hold[%0d]: got wr %b be %b wd %h addr %h done %b expected 1 0010 5a5a5a5a 00000200 0",
                 c, data_write, data_byteenable, data_writedata, data_address, done);
      end
      if (c == 2) begin
        @(posedge clk); #1;
        data_waitrequest = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || data_write !== 1'b0) begin
      errors++; $display("FAIL wait_done: got done %b wr %b expected 1 0", done, data_write);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wait_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    data_waitrequest = 1'b1; data_readdata = 32'hDEAD0001;
    start_op(OP_LW, 32'h100, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (data_read !== 1'b1) begin
      errors++; $display("FAIL abort_wait1: got rd %b expected 1", data_read);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, data_read, data_write} !== 4'b0000) begin
      errors++; $display("FAIL abort_ctrl: got busy/done/rd/wr %b expected 0000",
                         {busy, done, data_read, data_write});
    end
    checks++;
    if (data_address !== 32'h0 || data_byteenable !== 4'h0) begin
      errors++; $display("FAIL abort_bus: got addr %h be %b expected 00000000 0000",
                         data_address, data_byteenable);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got done %b expected 0", done);
    end
    data_waitrequest = 1'b0; data_readdata = 32'h0BADF00D;
    start_op(OP_LW, 32'h108, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (data_read !== 1'b1 || data_address !== 32'h108) begin
      errors++; $display("FAIL abort_restart_access: got rd %b addr %h expected 1 00000108",
                         data_read, data_address);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || load_data !== 32'h0BADF00D) begin
      errors++; $display("FAIL abort_restart_done: got done %b data %h expected 1 0badf00d",
                         done, load_data);
    end
  endtask

  task automatic test_busy_ignore();
    data_waitrequest = 1'b1; data_readdata = 32'h55AA55AA;
    start_op(OP_LW, 32'h10C, 32'h0, 32'h0);
    // A competing store request held high through ACCESS and DONE.
    start = 1'b1; op = OP_SW; addr = 32'h300; store_data = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (data_read !== 1'b1 || data_write !== 1'b0 || data_address !== 32'h10C) begin
      errors++; $display("FAIL busy_access1: got rd %b wr %b addr %h expected 1 0 0000010c",
                         data_read, data_write, data_address);
    end
    @(posedge clk); #1;
    data_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (data_read !== 1'b1 || data_address !== 32'h10C) begin
      errors++; $display("FAIL busy_access2: got rd %b addr %h expected 1 0000010c",
                         data_read, data_address);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || load_data !== 32'h55AA55AA || data_write !== 1'b0) begin
      errors++; $display("FAIL busy_done: got done %b data %h wr %b expected 1 55aa55aa 0",
                         done, load_data, data_write);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || data_write !== 1'b0) begin
      errors++; $display("FAIL busy_idle: got busy %b wr %b expected 0 0", busy, data_write);
    end
  endtask

  task automatic test_invalid_op();
    data_waitrequest = 1'b0; data_readdata = 32'hFFFFFFFF;
    start_op(4'd11, 32'h400, 32'h12345678, 32'h0);
    @(negedge clk);
    checks++;
    if ({busy, done, data_read, data_write} !== 4'b1100) begin
      errors++; $display("FAIL invalid_ctrl: got busy/done/rd/wr %b expected 1100",
                         {busy, done, data_read, data_write});
    end
    checks++;
    if (load_data !== 32'h0) begin
      errors++; $display("FAIL invalid_load_data: got %h expected 00000000", load_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL invalid_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_misaligned();
    data_waitrequest = 1'b0; data_readdata = 32'h11223344;
`ifdef LSU_ALIGN_CHECK_EN
    start_op(OP_SW, 32'h301, 32'hCAFEF00D, 32'h0);
    @(negedge clk);
    checks++;
    if ({done, err, data_write, data_read} !== 4'b1100 || load_data !== 32'h0) begin
      errors++; $display("FAIL align_sw: got done/err/wr/rd %b data %h expected 1100 00000000",
                         {done, err, data_write, data_read}, load_data);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL align_sw_idle: got busy/done/err %b expected 000",
                         {busy, done, err});
    end
    start_op(OP_LH, 32'h101, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({done, err, data_read} !== 3'b110) begin
      errors++; $display("FAIL align_lh: got done/err/rd %b expected 110", {done, err, data_read});
    end
    start_op(OP_LW, 32'h104, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({done, err} !== 2'b10 || load_data !== 32'h11223344) begin
      errors++; $display("FAIL align_lw_ok: got done/err %b data %h expected 10 11223344",
                         {done, err}, load_data);
    end
`else
    start_op(OP_LW, 32'h102, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (data_read !== 1'b1 || data_address !== 32'h100 || data_byteenable !== 4'b1111) begin
      errors++; $display("FAIL misalign_lw_access: got rd %b addr %h be %b expected 1 00000100 1111",
                         data_read, data_address, data_byteenable);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || load_data !== 32'h11223344) begin
      errors++; $display("FAIL misalign_lw_data: got done %b data %h expected 1 11223344",
                         done, load_data);
    end
    start_op(OP_SH, 32'h201, 32'h00001234, 32'h0);
    @(negedge clk);
    checks++;
    if (data_write !== 1'b1 || data_byteenable !== 4'b1100 ||
        data_writedata !== 32'h12341234 || data_address !== 32'h200) begin
      errors++; $display("FAIL misalign_sh: got wr %b be %b wd %h addr %h expected 1 1100 12341234 00000200",
                         data_write, data_byteenable, data_writedata, data_address);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL misalign_sh_done: got done %b expected 1", done);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_wait_state();
    test_reset_abort();
    test_busy_ignore();
    test_invalid_op();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_sequencer.md
LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: request strobe; sampled only in IDLE.
REQ-004 The block SHALL have port op, input, 4 bits: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; other codes are no-ops.
REQ-005 The block SHALL have ports addr (input, 32 bits: byte address), store_data (input, 32 bits: store value) and rt_data (input, 32 bits: old rt value used for LWL/LWR merge).
REQ-006 The block SHALL have ports busy (output, 1 bit), done (output, 1 bit: one-cycle completion pulse) and load_data (output, 32 bits: result, valid while done=1).
REQ-007 The block SHALL have memory ports data_address (output, 32 bits), data_read (output, 1), data_write (output, 1), data_byteenable (output, 4), data_writedata (output, 32), data_readdata (input, 32) and data_waitrequest (input, 1).

Function
REQ-008 The block SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-009 In IDLE with start=1 and a valid op, the block SHALL latch op, addr, store_data and rt_data, then move to ACCESS; with an invalid op it SHALL move directly to DONE with load_data=0.
REQ-010 In ACCESS the block SHALL drive data_address={addr[31:2],2'b00} and assert data_read (loads) or data_write (stores), holding all memory outputs stable while data_waitrequest=1.
REQ-011 On the first ACCESS cycle with data_waitrequest=0, the block SHALL capture data_readdata and move to DONE.
REQ-012 DONE SHALL last exactly one cycle with done=1, then return to IDLE; minimum start-to-done latency is 2 cycles.
REQ-013 busy SHALL be 1 in ACCESS and DONE and 0 in IDLE; start while busy=1 SHALL be ignored.
REQ-014 Byte lanes SHALL be big-endian: offset 0 maps to bits [31:24] and offset 3 to bits [7:0].
REQ-015 LB/LBU SHALL select the addressed byte and sign-extend or zero-extend it; LH/LHU SHALL select the half at addr[1] (0 gives [31:16]) and extend it; LW SHALL pass the word through.
REQ-016 LWL at offset k SHALL return the memory bytes k..3 placed from bit 31 downward, with the low k bytes taken from rt_data.
REQ-017 LWR at offset k SHALL return the memory bytes 0..k placed in the low bytes, with the upper 3-k bytes taken from rt_data.
REQ-018 Loads SHALL drive data_byteenable=4'b1111.
REQ-019 SB SHALL drive data_byteenable=4'b1000>>k and replicate store_data[7:0] into all four bytes.
REQ-020 SH SHALL drive data_byteenable=1100 (addr[1]=0) or 0011 (addr[1]=1) and replicate store_data[15:0].
REQ-021 SW SHALL drive data_byteenable=1111.
REQ-022 Misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0) SHALL use the truncated alignment, unless REQ-027 applies.
REQ-023 When not in ACCESS, data_read, data_write and data_byteenable SHALL be 0.

Reset
REQ-024 reset=1 SHALL force IDLE at the next edge, including mid-ACCESS, deasserting data_read and data_write in the following cycle.
REQ-025 Under reset, busy, done, load_data, data_address, data_writedata and data_byteenable SHALL all be 0.
REQ-026 A transaction aborted by reset SHALL produce no done pulse.

Configuration
REQ-027 With LSU_ALIGN_CHECK_EN defined, the block SHALL add output err (1 bit); a misaligned access per REQ-022 SHALL skip ACCESS and go straight to DONE with err=1 (for that cycle only) and load_data=0, with no memory strobe.
REQ-028 Without LSU_ALIGN_CHECK_EN, port err SHALL not exist and misaligned accesses SHALL follow REQ-022.

Verification
REQ-029 LW at addr 0x100, waitrequest=0, readdata=0x11223344 -> data_read=1 for 1 cycle, done 2 cycles after start, load_data=0x11223344.
REQ-030 LB at addr 0x103, readdata=0x000000F0 -> load_data=0xFFFFFFF0; the same access with LBU -> load_data=0x000000F0.
REQ-031 LWL at offset 1, readdata=0xAABBCCDD, rt=0x11223344 -> 0xBBCCDD44; LWR at offset 1 with the same inputs -> 0x1122AABB.
REQ-032 SB at addr 0x202, store_data=0x5A, waitrequest=1 for 3 cycles -> byteenable=0010, writedata=0x5A5A5A5A held stable for 4 cycles, done 1 cycle after waitrequest drops.
REQ-033 reset asserted on the 2nd wait cycle of an LW -> data_read=0 the following cycle, busy=0, no done pulse; a new start 1 cycle later is accepted.
REQ-034 With LSU_ALIGN_CHECK_EN, SW at addr 0x301 -> no data_write, err=1 and done=1 in the same cycle, 1 cycle after start.
